// File: rtl/sfr_bus_arbiter_pkg.sv
// sfr_bus_arbiter_pkg: FSM state encoding and pointer-width helper for the SFR bus arbiter.
package sfr_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/sfr_rr_picker.sv
// sfr_rr_picker: combinational round-robin pick of the first set request at or above ptr, wrapping.
module sfr_rr_picker import sfr_bus_arbiter_pkg::*; #(
  parameter int N = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] j;
  // Scan downward so the candidate closest to ptr is the last one written.
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = PW'((int'(ptr) + i) % N);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/sfr_bus_arbiter.sv
// sfr_bus_arbiter: round-robin sharing of one SFR bus among NUM_REQ requesters, three cycles per access.
// Define SFR_BUS_ARBITER_ILLEGAL_CHK_EN to add err_illegal and suppress strobes for we==re commands.
module sfr_bus_arbiter import sfr_bus_arbiter_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_re,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [ADDR_WIDTH-1:0]         sfr_address,
  output logic [DATA_WIDTH-1:0]         sfr_write_data,
  output logic                          sfr_we,
  output logic                          sfr_re,
  input  logic [DATA_WIDTH-1:0]         sfr_read_data
`ifdef SFR_BUS_ARBITER_ILLEGAL_CHK_EN
  ,
  output logic                          err_illegal
`endif
);
  localparam int PW = clog2(NUM_REQ);
  state_t state, state_next;
  logic [PW-1:0] ptr, g, pick;
  logic [NUM_REQ-1:0] grant, gnt;
  logic hs, cmd_we, cmd_re, wr_ok;

  sfr_rr_picker #(.N(NUM_REQ), .PW(PW)) picker (.req(req_valid), .ptr(ptr), .grant(grant), .idx(pick));

  assign cmd_we = req_we[pick];
  assign cmd_re = req_re[pick];
`ifdef SFR_BUS_ARBITER_ILLEGAL_CHK_EN
  assign wr_ok = cmd_we && !cmd_re;
`else
  assign wr_ok = cmd_we;
`endif

  always_comb begin
    state_next = state;
    req_ready = '0;
    rsp_valid = '0;
    hs = 1'b0;
    if (!reset) begin
      hs = state == IDLE && |req_valid;
      req_ready = hs ? grant : '0;
      rsp_valid = state == COMPLETE ? gnt : '0;
      state_next = state == COMPLETE ? IDLE : state == ACCESS ? COMPLETE : hs ? ACCESS : IDLE;
    end
  end

  always_ff @(posedge clk) state <= reset ? IDLE : state_next;

  // Strobes are set only on the handshake edge, so they fall by themselves after ACCESS.
  always_ff @(posedge clk)
    if (reset) begin
      ptr <= '0;
      g <= '0;
      gnt <= '0;
      sfr_address <= '0;
      sfr_write_data <= '0;
      sfr_we <= 1'b0;
      sfr_re <= 1'b0;
      rsp_rdata <= '0;
`ifdef SFR_BUS_ARBITER_ILLEGAL_CHK_EN
      err_illegal <= 1'b0;
`endif
    end else begin
      sfr_we <= hs && wr_ok;
      sfr_re <= hs && cmd_re && !cmd_we;
`ifdef SFR_BUS_ARBITER_ILLEGAL_CHK_EN
      err_illegal <= hs && cmd_we == cmd_re;
`endif
      if (hs) begin
        g <= pick;
        gnt <= grant;
        sfr_address <= req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
        sfr_write_data <= req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state == ACCESS && sfr_re) rsp_rdata <= sfr_read_data;
      if (state == COMPLETE) ptr <= int'(g) == NUM_REQ - 1 ? '0 : g + 1'b1;
    end
endmodule

// File: tb/tb_sfr_bus_arbiter.sv
// tb_sfr_bus_arbiter: directed stimulus with a response scoreboard for sfr_bus_arbiter.
module tb_sfr_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req_valid = '0, req_we = '0, req_re = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_ready, rsp_valid;
  logic [7:0] rsp_rdata, sfr_address, sfr_write_data, sfr_read_data;
  logic sfr_we, sfr_re;
`ifdef SFR_BUS_ARBITER_ILLEGAL_CHK_EN
  logic err_illegal;
`endif
  logic [7:0] mem [256];
  typedef struct { int idx; logic [7:0] rdata; } rsp_t;
  rsp_t sb[$];
  rsp_t mon_e;
  int checks = 0, errors = 0;
  logic [7:0] model_rd = '0;

  sfr_bus_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_re(req_re), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sfr_address(sfr_address),
    .sfr_write_data(sfr_write_data), .sfr_we(sfr_we), .sfr_re(sfr_re),
    .sfr_read_data(sfr_read_data)
`ifdef SFR_BUS_ARBITER_ILLEGAL_CHK_EN
    , .err_illegal(err_illegal)
`endif
  );

  always #5 clk = ~clk;
  assign sfr_read_data = mem[sfr_address];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void expect_rsp(int i, bit rd, logic [7:0] d);
    if (rd) model_rd = d;
    sb.push_back('{i, model_rd});
  endfunction

  always @(negedge clk)
    if (rsp_valid != 4'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=%b with nothing expected at %0t", rsp_valid, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_owner", 32'(rsp_valid), 32'(1) << mon_e.idx);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
      end
    end

  task automatic chk_zero(input string name);
    chk({name, "_hs"}, {24'b0, req_ready, rsp_valid}, 32'h0);
    chk({name, "_bus"}, {14'b0, sfr_we, sfr_re, sfr_address, sfr_write_data}, 32'h0);
    chk({name, "_rdata"}, 32'(rsp_rdata), 32'h0);
  endtask

  // Starts and ends at an IDLE-cycle falling edge.
  task automatic single(input int i, input bit we, input bit re, input logic [7:0] a,
                        input logic [7:0] d, input bit ewe, input bit ere, input logic [7:0] rd);
    req_valid = 4'(1) << i;
    req_we = 4'(we) << i;
    req_re = 4'(re) << i;
    req_addr[i*8 +: 8] = a;
    req_wdata[i*8 +: 8] = d;
    expect_rsp(i, ere, rd);
    #1 chk("single_ready", 32'(req_ready), 32'(1) << i);
    @(negedge clk);
    req_valid = '0;
    chk("single_we", 32'(sfr_we), 32'(ewe));
    chk("single_re", 32'(sfr_re), 32'(ere));
    chk("single_addr", 32'(sfr_address), 32'(a));
    if (ewe) chk("single_wdata", 32'(sfr_write_data), 32'(d));
`ifdef SFR_BUS_ARBITER_ILLEGAL_CHK_EN
    chk("single_err_illegal", 32'(err_illegal), 32'(we == re));
`endif
    @(negedge clk);
    chk("single_rsp_time", 32'(rsp_valid), 32'(1) << i);
    chk("single_strobes_low", {30'b0, sfr_we, sfr_re}, 32'h0);
    chk("single_addr_hold", 32'(sfr_address), 32'(a));
    @(negedge clk);
  endtask

  // All requesters in mask post reads at 0x40+i; seq lists the required grant order.
  task automatic grant_seq(input logic [3:0] mask, input int seq[5], input int n);
    bit again;
    req_valid = mask;
    req_we = '0;
    req_re = mask;
    for (int k = 0; k < 4; k++) req_addr[k*8 +: 8] = 8'(8'h40 + k);
    for (int k = 0; k < n; k++) expect_rsp(seq[k], 1'b1, 8'(8'h60 + seq[k]));
    for (int k = 0; k < n; k++) begin
      #1 chk("seq_grant", 32'(req_ready), 32'(1) << seq[k]);
      @(negedge clk);
      again = 1'b0;
      for (int j = k + 1; j < n; j++) if (seq[j] == seq[k]) again = 1'b1;
      if (!again) req_valid = req_valid & ~(4'(1) << seq[k]);
      chk("seq_addr", 32'(sfr_address), 32'(8'h40 + seq[k]));
      chk("seq_re", 32'(sfr_re), 32'h1);
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h30] = 8'h5C;
    for (int k = 0; k < 4; k++) mem[8'h40 + k] = 8'(8'h60 + k);
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    single(1, 1'b1, 1'b0, 8'h12, 8'hA5, 1'b1, 1'b0, 8'h00);
    single(2, 1'b0, 1'b1, 8'h30, 8'h00, 1'b0, 1'b1, 8'h5C);
    single(3, 1'b1, 1'b0, 8'h55, 8'h3C, 1'b1, 1'b0, 8'h00);
    chk("rdata_hold_after_write", 32'(rsp_rdata), 32'h5C);
    grant_seq(4'b0101, '{0, 2, 0, 0, 0}, 2);
`ifdef SFR_BUS_ARBITER_ILLEGAL_CHK_EN
    single(0, 1'b1, 1'b1, 8'h21, 8'h77, 1'b0, 1'b0, 8'h00);
`else
    single(0, 1'b1, 1'b1, 8'h21, 8'h77, 1'b1, 1'b0, 8'h00);
`endif
    single(1, 1'b0, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00);
    req_valid = 4'b0010;
    req_we = '0;
    req_re = 4'b0010;
    req_addr[15:8] = 8'h30;
    #1 chk("abort_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    chk("abort_strobe", 32'(sfr_re), 32'h1);
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk_zero("abort");
    model_rd = '0;
    reset = 1'b0;
    grant_seq(4'b1010, '{1, 3, 0, 0, 0}, 2);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_rd = '0;
    reset = 1'b0;
    grant_seq(4'b1111, '{0, 1, 2, 3, 0}, 5);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfr_bus_arbiter.md
Name: sfr_bus_arbiter

Overview:
- Shares one SFR master bus (address, write_data, we, re, read_data) among NUM_REQ independent requesters.
- Each requester posts a single read or write command using a valid/ready handshake. The arbiter grants requesters round-robin and sequences the two-cycle SFR access.
- For every accepted command it returns a one-cycle response pulse; for reads, the pulse carries the read data.
- Sits between the register-access clients (bus bridges, sequencer BFMs, on-chip config engines) and the SFR slave register bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 8, SFR address width
- DATA_WIDTH, 8, SFR data width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_we  in  NUM_REQ  write command
- req_re  in  NUM_REQ  read command
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data; same packing
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- sfr_address  out  ADDR_WIDTH  SFR address
- sfr_write_data  out  DATA_WIDTH  SFR write data
- sfr_we  out  1  SFR write strobe
- sfr_re  out  1  SFR read strobe
- sfr_read_data  in  DATA_WIDTH  SFR read data

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk.
- During reset all outputs are 0, state is IDLE and the round-robin pointer is 0.
- Reset mid-access: the access is abandoned and no rsp_valid is issued. The requester must re-post after reset.
- FSM states: IDLE, ACCESS, COMPLETE.
- IDLE:
  - If any req_valid is high, select the first set bit searching from the pointer upward, wrapping modulo NUM_REQ.
  - req_ready[g] is driven combinationally high for that requester only.
  - On the handshake edge, latch g, addr, wdata, we and re, then go to ACCESS.
  - If no req_valid is high, req_ready is 0.
- ACCESS (one cycle):
  - sfr_address and sfr_write_data are driven from the latch.
  - sfr_we or sfr_re is high, registered.
  - On the closing edge, sfr_read_data is captured into rsp_rdata if the access is a read; the FSM goes to COMPLETE.
- COMPLETE (one cycle):
  - sfr_we and sfr_re are low; sfr_address holds its value.
  - rsp_valid[g] is high for exactly one cycle.
  - The pointer becomes (g+1) mod NUM_REQ; the FSM returns to IDLE.
- Timing:
  - Handshake in cycle T, strobe in T+1, rsp_valid in T+2.
  - The next grant can occur at T+3, so throughput is one access per 3 cycles.
- Response data:
  - rsp_rdata holds its last value between reads.
  - For a write, rsp_rdata is left unchanged.
- Handshake rules:
  - req_valid, together with its command fields, must remain stable until req_ready.
  - Deasserting req_valid before it is accepted is permitted and simply withdraws the request.
- Simultaneous requests: exactly one requester is granted; the others wait and keep their valid asserted.
- Starvation bound: a requester is served within NUM_REQ grants.
- we and re both high: treated as a write; sfr_re stays 0.
- Neither we nor re high: the access runs with both strobes low and still produces rsp_valid.

Optional Feature:
- Macro: SFR_BUS_ARBITER_ILLEGAL_CHK_EN.
- Defined:
  - Adds output err_illegal (1 bit, reset 0).
  - err_illegal pulses high in the handshake-following cycle whenever the accepted command has we==re.
  - An illegal command produces no SFR strobes but still produces rsp_valid.
- Undefined:
  - The err_illegal port is absent.
  - Illegal commands behave as described in Behaviour.

Decomposition:
- Package sfr_bus_arbiter_pkg contains:
  - the state enum (IDLE, ACCESS, COMPLETE)
  - the clog2 helper for pointer width
- Sub-module sfr_rr_picker:
  - Purely combinational.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Instantiated once.

Test Plan:
- Single write: req 1 posts addr=0x12, wdata=0xA5.
  - req_ready[1] is high in T.
  - T+1: sfr_we=1, sfr_address=0x12, sfr_write_data=0xA5.
  - T+2: rsp_valid[1]=1, sfr_we=0.
- Single read: req 2 posts addr=0x30; slave returns 0x5C.
  - T+1: sfr_re=1.
  - T+2: rsp_valid[2]=1, rsp_rdata=0x5C.
- Contention: all 4 requesters valid from reset release.
  - Grant order is 0,1,2,3, at 3-cycle spacing.
  - Requester 0 re-posts immediately and is next granted after 3.
- Wrap and pointer: after serving requester 3, with requesters 0 and 2 valid, requester 0 is granted first; after it, requester 2.
- Reset in ACCESS: reset asserted during a read's strobe cycle.
  - The next cycle shows all outputs 0 and no rsp_valid.
  - A post-reset request from requester 3 is granted with the pointer at 0.
- Illegal command with macro defined: req 0 posts we=1, re=1.
  - err_illegal pulses at T+1, no strobe occurs, rsp_valid[0] at T+2.
  - With the macro undefined, sfr_we=1 and sfr_re=0 at T+1.
